// File: rtl/mxrv_defines.sv
// Shared constants for the mxrv fetch slice: datapath width, reset vector,
// PC step and the canonical NOP encoding.
package mxrv_defines;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/mxrv_fetch_buf.sv
// Circular instruction buffer holding packed {pc, inst} entries; the head entry
// is always presented, flush empties it in one cycle.
module mxrv_fetch_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // NOTE: storage is reset so the head outputs read as zero out of reset;
    // the array is tiny, so this costs only a handful of flop resets.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/mxrv_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited ROM requests,
// buffers 1-cycle-latency responses and hands {pc, inst} pairs to decode.
module mxrv_fetch
    import mxrv_defines::*;
#(
    parameter int              XLEN      = mxrv_defines::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = mxrv_defines::RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] rom_pc_o,
    output logic            rom_rd_valid_o,
    input  logic            rom_rd_ready_i,
    input  logic [XLEN-1:0] rom_inst_i,
    input  logic            rom_inst_valid_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_inst_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic            misalign_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc_q;
    logic [XLEN-1:0]   req_pc_q;
    logic              outstanding_q;
    logic              drop_q;
    logic              misalign_q;

    logic [CW-1:0]     buf_count;
    logic              buf_empty;
    logic [2*XLEN-1:0] buf_head;

    logic              pop;
    logic              resp;
    logic              push;
    logic              accept;
    logic [CW:0]       in_use;

    assign pop  = id_valid_o && id_ready_i;
    assign resp = rom_inst_valid_i && outstanding_q;
    assign push = resp && !drop_q && !redirect_i;

    // Slots committed for the next cycle: the entry leaving this cycle frees its
    // slot, which is what lets a two-entry buffer sustain one fetch per cycle.
    assign in_use = {1'b0, buf_count} + (CW+1)'(outstanding_q) - (CW+1)'(pop);

    assign rom_rd_valid_o = rst_n && !halt_i && !redirect_i
                            && (in_use < (CW+1)'(BUF_DEPTH));
    assign accept         = rom_rd_valid_o && rom_rd_ready_i;
    assign rom_pc_o       = fetch_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            outstanding_q <= accept || (outstanding_q && !resp);
            misalign_q    <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                fetch_pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
                // A response landing this cycle is already killed by the flush.
                drop_q     <= outstanding_q && !resp;
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + XLEN'(WORD_STEP);
                    req_pc_q   <= fetch_pc_q;
                end
                if (resp) begin
                    drop_q <= 1'b0;
                end
            end
        end
    end

    mxrv_fetch_buf #(
        .WIDTH (2*XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({req_pc_q, rom_inst_i}),
        .pop       (pop),
        .flush     (redirect_i),
        .head_data (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign id_valid_o           = !buf_empty;
    assign {id_pc_o, id_inst_o} = buf_head;
    assign misalign_o           = misalign_q;

endmodule

// File: tb/tb_mxrv_fetch.sv
// Self-checking bench for mxrv_fetch: cycle table after reset plus directed
// sequences for redirect, decode stall, ROM backpressure, halt and reset.
module tb_mxrv_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_pc_o;
    logic        rom_rd_valid_o;
    logic        rom_rd_ready_i;
    logic [31:0] rom_inst_i = 32'h0;
    logic        rom_inst_valid_i = 1'b0;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mxrv_fetch #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rom_pc_o         (rom_pc_o),
        .rom_rd_valid_o   (rom_rd_valid_o),
        .rom_rd_ready_i   (rom_rd_ready_i),
        .rom_inst_i       (rom_inst_i),
        .rom_inst_valid_i (rom_inst_valid_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .halt_i           (halt_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_inst_o        (id_inst_o),
        .id_pc_o          (id_pc_o),
        .misalign_o       (misalign_o)
    );

    // ROM model: word k holds value k; when idle it may wave garbage with valid high.
    always @(posedge clk) begin
        if (rom_rd_valid_o && rom_rd_ready_i) begin
            rom_inst_i       <= {2'b00, rom_pc_o[31:2]};
            rom_inst_valid_i <= 1'b1;
        end else begin
            rom_inst_i       <= 32'hdead_beef;
            rom_inst_valid_i <= 1'($urandom_range(0, 1));
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } obs_t;

    typedef struct {
        logic        id_ready;
        logic        rom_ready;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        halt;
        logic        e_rom_valid;
        logic [31:0] e_rom_pc;
        logic        e_id_valid;
        logic [31:0] e_id_pc;
        logic [31:0] e_id_inst;
        logic        e_misalign;
    } vec_t;

    obs_t log_q[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_req    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive point of the next cycle (2 ns after the rising edge).
    task automatic cycle_begin();
        @(posedge clk);
        #2;
    endtask

    // Observation point (3 ns before the next rising edge); logs handshakes.
    task automatic cycle_end();
        #5;
        if (rst_n && id_valid_o && id_ready_i) log_q.push_back('{id_pc_o, id_inst_o});
        if (rst_n && rom_rd_valid_o && rom_rd_ready_i) n_req++;
    endtask

    task automatic tick();
        cycle_end();
        cycle_begin();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready_i     = 1'b1;
        rom_rd_ready_i = 1'b1;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        halt_i         = 1'b0;
        cycle_begin();
        cycle_begin();
        rst_n = 1'b1;
        log_q.delete();
    endtask

    task automatic check_stream(input string name, input logic [31:0] base, input int min_n);
        check($sformatf("%s entries", name),
              (log_q.size() >= min_n) ? 32'(min_n) : 32'(log_q.size()), 32'(min_n));
        foreach (log_q[i]) begin
            check($sformatf("%s pc[%0d]", name, i), log_q[i].pc, base + 32'(4 * i));
            check($sformatf("%s inst[%0d]", name, i), log_q[i].inst, (base >> 2) + 32'(i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          first_seen;
        int          mark;
        int          req0;
        logic        prev_pend;
        logic [31:0] prev_pc;

        // id_ready, rom_ready, redirect, redirect_pc, halt | rom_valid, rom_pc, id_valid, id_pc, id_inst, misalign
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 32'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 32'h00, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0c, 1'b1, 32'h04, 32'h01, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 32'h02, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0c, 32'h03, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 32'h00, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h44, 1'b0, 32'h00, 32'h00, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h48, 1'b1, 32'h40, 32'h10, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4c, 1'b1, 32'h44, 32'h11, 1'b0};

        rst_n          = 1'b0;
        id_ready_i     = 1'b1;
        rom_rd_ready_i = 1'b1;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        halt_i         = 1'b0;
        #7;
        check("reset rom_rd_valid", 32'(rom_rd_valid_o), 32'd0);
        check("reset id_valid",     32'(id_valid_o),     32'd0);
        check("reset id_pc",        id_pc_o,             32'h0);
        check("reset id_inst",      id_inst_o,           32'h0);
        check("reset misalign",     32'(misalign_o),     32'd0);

        // Streaming start-up, then a misaligned redirect to 0x42.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            id_ready_i     = tbl[i].id_ready;
            rom_rd_ready_i = tbl[i].rom_ready;
            redirect_i     = tbl[i].redirect;
            redirect_pc_i  = tbl[i].redirect_pc;
            halt_i         = tbl[i].halt;
            cycle_end();
            check($sformatf("tbl[%0d] rom_rd_valid", i), 32'(rom_rd_valid_o), 32'(tbl[i].e_rom_valid));
            if (tbl[i].e_rom_valid)
                check($sformatf("tbl[%0d] rom_pc", i), rom_pc_o, tbl[i].e_rom_pc);
            check($sformatf("tbl[%0d] id_valid", i), 32'(id_valid_o), 32'(tbl[i].e_id_valid));
            if (tbl[i].e_id_valid) begin
                check($sformatf("tbl[%0d] id_pc", i),   id_pc_o,   tbl[i].e_id_pc);
                check($sformatf("tbl[%0d] id_inst", i), id_inst_o, tbl[i].e_id_inst);
            end
            check($sformatf("tbl[%0d] misalign", i), 32'(misalign_o), 32'(tbl[i].e_misalign));
            cycle_begin();
        end

        // Aligned redirect with a request in flight.
        do_reset();
        repeat (4) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        cycle_end();
        check("redir rom_rd_valid in R", 32'(rom_rd_valid_o), 32'd0);
        mark = log_q.size();
        cycle_begin();
        redirect_i = 1'b0;
        first_seen = -1;
        for (int k = 1; k <= 6; k++) begin
            cycle_end();
            if (k == 1) check("redir aligned misalign", 32'(misalign_o), 32'd0);
            if (first_seen < 0 && id_valid_o) begin
                first_seen = k;
                check("redir first id_pc", id_pc_o, 32'h40);
            end
            cycle_begin();
        end
        check("redir latency", 32'(first_seen), 32'd3);
        check("redir first logged pc",
              (log_q.size() > mark) ? log_q[mark].pc : 32'hffff_ffff, 32'h40);

        // Decode stall for 10 cycles.
        do_reset();
        repeat (5) tick();
        id_ready_i = 1'b0;
        req0 = n_req;
        for (int s = 0; s < 10; s++) begin
            cycle_end();
            if (s == 9) begin
                check("stall rom_rd_valid", 32'(rom_rd_valid_o), 32'd0);
                check("stall id_valid",     32'(id_valid_o),     32'd1);
            end
            cycle_begin();
        end
        check("stall requests bounded", (n_req - req0 <= 2) ? 32'd1 : 32'(n_req - req0), 32'd1);
        id_ready_i = 1'b1;
        repeat (10) tick();
        check_stream("stall", 32'h0, 10);

        // Random ROM backpressure.
        do_reset();
        prev_pend = 1'b0;
        prev_pc   = 32'h0;
        for (int c = 0; c < 60; c++) begin
            rom_rd_ready_i = 1'($urandom_range(0, 1));
            cycle_end();
            if (prev_pend) begin
                check($sformatf("bp[%0d] rom_pc held", c), rom_pc_o, prev_pc);
                check($sformatf("bp[%0d] rom_rd_valid held", c), 32'(rom_rd_valid_o), 32'd1);
            end
            prev_pend = rom_rd_valid_o && !rom_rd_ready_i;
            prev_pc   = rom_pc_o;
            cycle_begin();
        end
        rom_rd_ready_i = 1'b1;
        repeat (4) tick();
        check_stream("bp", 32'h0, 8);

        // Halt mid-stream, then reset with a response in flight.
        do_reset();
        repeat (6) tick();
        halt_i = 1'b1;
        req0 = n_req;
        for (int h = 0; h < 8; h++) begin
            cycle_end();
            check($sformatf("halt[%0d] rom_rd_valid", h), 32'(rom_rd_valid_o), 32'd0);
            if (h == 7) check("halt drained id_valid", 32'(id_valid_o), 32'd0);
            cycle_begin();
        end
        check("halt requests", 32'(n_req - req0), 32'd0);
        check_stream("halt", 32'h0, 6);
        halt_i = 1'b0;
        cycle_end();
        check("unhalt rom_rd_valid", 32'(rom_rd_valid_o), 32'd1);
        cycle_begin();
        rst_n = 1'b0;
        #1;
        check("async reset id_valid",     32'(id_valid_o),     32'd0);
        check("async reset rom_rd_valid", 32'(rom_rd_valid_o), 32'd0);
        check("async reset misalign",     32'(misalign_o),     32'd0);
        cycle_begin();
        cycle_begin();
        rst_n = 1'b1;
        log_q.delete();
        cycle_end();
        check("restart rom_rd_valid", 32'(rom_rd_valid_o), 32'd1);
        check("restart rom_pc",       rom_pc_o,             32'h0);
        cycle_begin();
        repeat (6) tick();
        check_stream("restart", 32'h0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
